// File: rtl/tree_ram_arbiter.sv
// Single-port arbiter for the tree sprite RAM: round-robin readers and a loader
// write port with a bounded write streak, plus an exclusive LOAD mode for repaints.
module tree_ram_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned MAX_WR_BURST = 4
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      wr_valid,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ready,
    input  logic                      load_start,
    input  logic                      load_done,
    output logic                      loading,
    output logic [ADDR_W-1:0]         ram_read_address,
    output logic [ADDR_W-1:0]         ram_write_address,
    output logic [DATA_W-1:0]         ram_data_In,
    output logic                      ram_we,
    input  logic [DATA_W-1:0]         ram_data_Out
);

    localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STREAK_W = $clog2(MAX_WR_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_BURST);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    rd_cand;
    logic                rd_found;
    logic [STREAK_W-1:0] wr_streak;
    logic                read_pending;
    logic                wr_grant;
    logic                rd_grant;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    assign rsp_data = ram_data_Out;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; load_done dominates a simultaneous load_start
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (load_start && !load_done) state_nxt = ST_LOAD;
            ST_LOAD: if (load_done)                state_nxt = ST_RUN;
        endcase
    end

    // Round-robin search starting just after the last granted reader
    always_comb begin
        rd_found = 1'b0;
        rd_idx   = '0;
        rd_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rd_cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!rd_found && req_valid[rd_cand]) begin
                rd_found = 1'b1;
                rd_idx   = rd_cand;
            end
        end
    end

    // Grant decision; nothing is granted while reset is asserted
    always_comb begin
        read_pending = |req_valid;
        wr_grant     = 1'b0;
        rd_grant     = 1'b0;
        if (Reset_n) begin
            if (state == ST_LOAD) begin
                wr_grant = wr_valid;
            end else begin
                wr_grant = wr_valid && (!read_pending || (wr_streak < STREAK_MAX));
                rd_grant = !wr_grant && rd_found;
            end
        end
    end

    // Output decode
    always_comb begin
        req_ready         = '0;
        wr_ready          = 1'b0;
        ram_we            = 1'b0;
        ram_write_address = '0;
        ram_data_In       = '0;
        ram_read_address  = '0;
        if (wr_grant) begin
            wr_ready          = 1'b1;
            ram_we            = 1'b1;
            ram_write_address = wr_addr;
            ram_data_In       = wr_data;
        end
        if (rd_grant) begin
            req_ready[rd_idx] = 1'b1;
            ram_read_address  = addr_arr[rd_idx];
        end
    end

    // Pointer, write streak and response tag pipeline aligned to the RAM latency
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            wr_streak <= '0;
            rsp_valid <= '0;
            loading   <= 1'b0;
        end else begin
            if (rd_grant) begin
                rr_ptr <= rd_idx;
            end
            if (rd_grant || !read_pending) begin
                wr_streak <= '0;
            end else if (wr_grant && (wr_streak < STREAK_MAX)) begin
                wr_streak <= wr_streak + STREAK_W'(1);
            end
            rsp_valid <= req_ready;
            loading   <= (state_nxt == ST_LOAD);
        end
    end

endmodule

// File: tb/tb_tree_ram_arbiter.sv
// Directed bench for tree_ram_arbiter: stimulus queues expected read responses,
// a negedge monitor checks grants every cycle and pops responses when due.
module tb_tree_ram_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned DATA_W  = 4;

    logic                      Clk = 1'b0;
    logic                      Reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      wr_valid;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      wr_ready;
    logic                      load_start;
    logic                      load_done;
    logic                      loading;
    logic [ADDR_W-1:0]         ram_read_address;
    logic [ADDR_W-1:0]         ram_write_address;
    logic [DATA_W-1:0]         ram_data_In;
    logic                      ram_we;
    logic [DATA_W-1:0]         ram_data_Out;

    always #5 Clk = ~Clk;

    tree_ram_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WR_BURST(4)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .load_start(load_start), .load_done(load_done), .loading(loading),
        .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
        .ram_data_In(ram_data_In), .ram_we(ram_we), .ram_data_Out(ram_data_Out)
    );

    // Behavioural sprite RAM with a registered read
    logic [DATA_W-1:0] mem [8192];
    always @(posedge Clk) begin
        if (ram_we) mem[ram_write_address] <= ram_data_In;
        ram_data_Out <= mem[ram_read_address];
    end

    int cycle_cnt = 0;
    always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

    typedef struct packed {
        logic [31:0] due;
        logic [3:0]  vld;
        logic [3:0]  data;
    } rsp_t;

    rsp_t q[$];
    int   rd_ptr = 0;
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;

    logic [3:0]  e_rr;
    logic        e_wr;
    logic [12:0] e_raddr;
    logic [12:0] e_waddr;
    logic [3:0]  e_wdata;
    logic        e_ld;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cycle_cnt, act, exp);
        end
    endtask

    // Monitor: combinational grants each cycle, responses when their due cycle arrives
    always @(negedge Clk) begin
        chk("req_ready", 16'(req_ready), 16'(e_rr));
        chk("wr_ready", 16'(wr_ready), 16'(e_wr));
        chk("ram_we", 16'(ram_we), 16'(e_wr));
        chk("ram_read_address", 16'(ram_read_address), 16'(e_raddr));
        chk("ram_write_address", 16'(ram_write_address), 16'(e_waddr));
        chk("ram_data_In", 16'(ram_data_In), 16'(e_wdata));
        chk("loading", 16'(loading), 16'(e_ld));
        if (rd_ptr < q.size() && q[rd_ptr].due == 32'(cycle_cnt)) begin
            chk("rsp_valid", 16'(rsp_valid), 16'(q[rd_ptr].vld));
            chk("rsp_data", 16'(rsp_data), 16'(q[rd_ptr].data));
            rd_ptr++;
        end else begin
            chk("rsp_valid_idle", 16'(rsp_valid), 16'h0);
        end
        if (done) chk("scoreboard_drained", 16'(q.size() - rd_ptr), 16'h0);
    end

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_exp(input logic [3:0] rr, input logic wr, input logic [12:0] raddr,
                           input logic [12:0] waddr, input logic [3:0] wdata, input logic ld);
        e_rr = rr; e_wr = wr; e_raddr = raddr; e_waddr = waddr; e_wdata = wdata; e_ld = ld;
    endtask

    task automatic exp_rd(input int g, input logic [12:0] a, input logic [3:0] d, input logic ld);
        rsp_t e;
        set_exp(4'(1 << g), 1'b0, a, 13'h0, 4'h0, ld);
        e.due  = 32'(cycle_cnt + 1);
        e.vld  = 4'(1 << g);
        e.data = d;
        q.push_back(e);
    endtask

    task automatic exp_wr(input logic [12:0] a, input logic [3:0] d, input logic ld);
        set_exp(4'h0, 1'b1, 13'h0, a, d, ld);
    endtask

    task automatic exp_idle(input logic ld);
        set_exp(4'h0, 1'b0, 13'h0, 13'h0, 4'h0, ld);
    endtask

    task automatic set_addr(input int i, input logic [12:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 4'h0;
        mem[13'h010] = 4'hA;
        for (int i = 0; i < 4; i++) mem[13'h100 + 13'(i)] = 4'(i + 1);
        mem[13'h300] = 4'h7;

        // Reset with every request asserted: nothing may be granted
        Reset_n = 1'b0; req_valid = 4'hF; wr_valid = 1'b1; wr_addr = 13'h1FF; wr_data = 4'hF;
        load_start = 1'b0; load_done = 1'b0; req_addr = '0;
        for (int i = 0; i < 4; i++) set_addr(i, 13'h100 + 13'(i));
        exp_idle(1'b0);
        repeat (3) nxt();
        Reset_n = 1'b1; req_valid = 4'h0; wr_valid = 1'b0; wr_addr = 13'h0; wr_data = 4'h0;
        repeat (5) nxt();

        // First priority after reset goes to requester 0
        req_valid = 4'hF; exp_rd(0, 13'h100, 4'h1, 1'b0);
        nxt(); req_valid = 4'b0001; set_addr(0, 13'h010); exp_rd(0, 13'h010, 4'hA, 1'b0);

        // Round robin with all requesters valid
        nxt(); set_addr(0, 13'h100); req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) nxt();
            exp_rd((k + 1) % 4, 13'h100 + 13'((k + 1) % 4), 4'((k + 1) % 4 + 1), 1'b0);
        end
        nxt(); req_valid = 4'h0; exp_idle(1'b0);

        // Write streak limit against a single pending reader
        nxt(); req_valid = 4'b0100; set_addr(2, 13'h300); wr_valid = 1'b1; wr_addr = 13'h200; wr_data = 4'h9;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) nxt();
            if (k % 5 == 4) exp_rd(2, 13'h300, 4'h7, 1'b0);
            else            exp_wr(13'h200, 4'h9, 1'b0);
        end
        nxt(); wr_valid = 1'b0; req_valid = 4'h0; set_addr(2, 13'h102); exp_idle(1'b0);

        // Read immediately after a write to the same address
        nxt(); wr_valid = 1'b1; wr_addr = 13'h123; wr_data = 4'h5; exp_wr(13'h123, 4'h5, 1'b0);
        nxt(); wr_valid = 1'b0; req_valid = 4'b0010; set_addr(1, 13'h123); exp_rd(1, 13'h123, 4'h5, 1'b0);
        nxt(); req_valid = 4'h0; set_addr(1, 13'h101); exp_idle(1'b0);

        // LOAD entry with a read in flight, writes only while loading
        nxt(); req_valid = 4'hF; load_start = 1'b1; exp_rd(2, 13'h102, 4'h3, 1'b0);
        nxt(); load_start = 1'b0; exp_idle(1'b1);
        nxt(); wr_valid = 1'b1; wr_addr = 13'h101; wr_data = 4'hC; exp_wr(13'h101, 4'hC, 1'b1);
        nxt(); wr_addr = 13'h102; wr_data = 4'hD; exp_wr(13'h102, 4'hD, 1'b1);
        nxt(); wr_addr = 13'h103; wr_data = 4'hE; exp_wr(13'h103, 4'hE, 1'b1);
        nxt(); wr_addr = 13'h100; wr_data = 4'hB; exp_wr(13'h100, 4'hB, 1'b1);
        nxt(); wr_addr = 13'h1F0; wr_data = 4'h6; exp_wr(13'h1F0, 4'h6, 1'b1);
        nxt(); wr_valid = 1'b0; wr_addr = 13'h0; wr_data = 4'h0; load_done = 1'b1; exp_idle(1'b1);
        nxt(); load_done = 1'b0; exp_rd(3, 13'h103, 4'hE, 1'b0);
        nxt(); exp_rd(0, 13'h100, 4'hB, 1'b0);
        nxt(); exp_rd(1, 13'h101, 4'hC, 1'b0);
        nxt(); exp_rd(2, 13'h102, 4'hD, 1'b0);

        // Simultaneous load_start and load_done stays in RUN
        nxt(); req_valid = 4'h0; load_start = 1'b1; load_done = 1'b1; exp_idle(1'b0);
        nxt(); load_start = 1'b0; load_done = 1'b0; req_valid = 4'b0001; set_addr(0, 13'h010);
        exp_rd(0, 13'h010, 4'hA, 1'b0);

        // Reset while a response is in flight: response is dropped
        nxt(); req_valid = 4'b0010; set_addr(1, 13'h123);
        set_exp(4'b0010, 1'b0, 13'h123, 13'h0, 4'h0, 1'b0);
        nxt(); Reset_n = 1'b0; req_valid = 4'h0; exp_idle(1'b0);
        nxt(); Reset_n = 1'b1;
        nxt(); req_valid = 4'hF; set_addr(0, 13'h100); set_addr(1, 13'h101);
        exp_rd(0, 13'h100, 4'hB, 1'b0);
        nxt(); req_valid = 4'h0; exp_idle(1'b0);
        nxt(); done = 1'b1;
        @(negedge Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tree_ram_arbiter.md
Name: tree_ram_arbiter

Overview:
Shares the single read port of the tree sprite RAM (4-bit palette index, 13-bit address, 1-cycle registered read) between NUM_REQ tree-instance pixel fetchers and a sprite loader write port. It arbitrates once per cycle: round-robin among the readers, and writes take priority subject to a streak limit. Each read response is returned one-hot tagged, aligned to the RAM's read latency. A LOAD mode gives the loader exclusive access while it repaints sprite data.

Parameters:
NUM_REQ, 4, number of read requesters
ADDR_W, 13, RAM address width
DATA_W, 4, RAM data width (palette index)
MAX_WR_BURST, 4, maximum consecutive write grants in RUN mode while any read is pending

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  read request per requester
req_addr  in  NUM_REQ*ADDR_W  read address; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  one-hot read grant (combinational)
rsp_valid  out  NUM_REQ  one-hot registered flag: read data valid for that requester
rsp_data  out  DATA_W  read data, passed through from ram_data_Out
wr_valid  in  1  loader write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  write grant (combinational)
load_start  in  1  pulse: enter LOAD mode
load_done  in  1  pulse: leave LOAD mode
loading  out  1  high while in LOAD
ram_read_address  out  ADDR_W  to RAM read_address
ram_write_address  out  ADDR_W  to RAM write_address
ram_data_In  out  DATA_W  to RAM data_In
ram_we  out  1  to RAM we
ram_data_Out  in  DATA_W  from RAM data_Out

Behaviour:
- Reset (async, Reset_n=0):
  - state=RUN; rr_ptr=NUM_REQ-1, so requester 0 has first priority; wr_streak=0.
  - rsp_valid=0. loading=0.
  - All combinational outputs evaluate to 0 because no request can be granted while in reset.
- One access per cycle. A read grant and a write grant are never asserted in the same cycle.
- FSM states RUN and LOAD:
  - RUN -> LOAD on load_start.
  - LOAD -> RUN on load_done.
  - If load_start and load_done are both high, load_done wins; the state becomes or stays RUN.
  - loading = (state==LOAD), registered.
- RUN arbitration:
  - Write grant when wr_valid=1 and either no read is pending or wr_streak<MAX_WR_BURST.
  - Otherwise read grant goes to the first i with req_valid[i]=1, searching from rr_ptr+1 modulo NUM_REQ.
- LOAD arbitration: only writes are granted; req_ready=0 always.
- wr_streak:
  - Increments on each write grant while any req_valid is high, saturating at MAX_WR_BURST.
  - Clears on any read grant, or on any cycle where no read is pending.
- rr_ptr updates to the granted index on each read grant only.
- Write grant drives ram_we=1, ram_write_address=wr_addr and ram_data_In=wr_data in the same cycle. Otherwise ram_we=0 and write address/data are 0.
- Read grant to requester i:
  - In cycle N: ram_read_address=req_addr[i].
  - In cycle N+1: rsp_valid=one-hot(i), and rsp_data=ram_data_Out.
  - With no read grant, ram_read_address=0 and rsp_valid=0 the next cycle.
- Throughput: back-to-back reads, 1 per cycle, with responses pipelined. Requesters must hold req_valid and req_addr until req_ready is seen.
- Ordering: a read granted the cycle after a write to the same address returns the new data.
- Reset mid-operation clears any in-flight rsp_valid. The response for that access is lost and no stale flag appears after reset.
- load_start while a read is in flight: the in-flight response still completes the next cycle.

Test Plan:
- Reset then idle: all outputs 0, loading=0; hold 5 cycles -> still 0.
- Preload mem[0x010]=0xA. req_valid=4'b0001, addr0=0x010 -> req_ready=0001 in cycle N; cycle N+1 rsp_valid=0001, rsp_data=0xA.
- All four requesters valid continuously -> grants cycle through 0,1,2,3,0,1; rsp_valid follows one cycle later with the matching address data.
- wr_valid held high with req_valid[2] high -> 4 write grants, 1 read grant to requester 2, then 4 writes; repeat.
- Write 0x5 to 0x123; next cycle requester 1 reads 0x123 -> rsp_valid=0010, rsp_data=0x5.
- Pulse load_start with all reads valid -> loading=1, req_ready=0, only writes granted. Pulse load_done -> loading=0 and reads resume at rr_ptr+1. Assert Reset_n=0 mid-read -> rsp_valid=0 the following cycle.
